// File: rtl/stun_controller.sv
// stun_controller: bomb lifecycle sequencer (IDLE -> FUSE -> BLAST -> COOLDOWN)
// with blast-box hit detection and independent per-player stun timers.
module stun_controller #(
  parameter int FUSE_CYCLES     = 100,
  parameter int BLAST_CYCLES    = 10,
  parameter int STUN_CYCLES     = 200,
  parameter int COOLDOWN_CYCLES = 50,
  parameter int BLAST_RADIUS    = 16,
  parameter int CNT_W           = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bomb_request,
  input  logic [9:0] bomb_x_in,
  input  logic [8:0] bomb_y_in,
  input  logic [9:0] red_x,
  input  logic [8:0] red_y,
  input  logic [9:0] blue_x,
  input  logic [8:0] blue_y,
  output logic       bomb_accepted,
  output logic       bomb_active,
  output logic       bomb_exploding,
  output logic [9:0] bomb_x,
  output logic [8:0] bomb_y,
  output logic       red_stun,
  output logic       blue_stun
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FUSE     = 2'd1;
  localparam logic [1:0] BLAST    = 2'd2;
  localparam logic [1:0] COOLDOWN = 2'd3;

  // Phase counters hold "cycles remaining minus one" so a zero count marks
  // the last cycle of the phase.
  localparam logic [CNT_W-1:0] FUSE_LOAD     = CNT_W'(FUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLAST_LOAD    = CNT_W'(BLAST_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOLDOWN_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
  // Stun counters hold "cycles of stun still to show"; nonzero means stunned.
  localparam logic [CNT_W-1:0] STUN_LOAD     = CNT_W'(STUN_CYCLES);
  localparam logic [31:0]      RADIUS        = 32'(BLAST_RADIUS);

  logic [1:0]       state;
  logic [CNT_W-1:0] phaseCnt;
  logic             acceptedReg;
  logic [9:0]       bombXReg;
  logic [8:0]       bombYReg;
  logic [CNT_W-1:0] redCnt;
  logic [CNT_W-1:0] blueCnt;
  logic             redHitFlag;
  logic             blueHitFlag;
  logic             acceptNow;
  logic             redHit;
  logic             blueHit;

  // Unsigned absolute difference at full width; never wraps.
  function automatic logic [9:0] absDiffX(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [8:0] absDiffY(input logic [8:0] a, input logic [8:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Inclusive square box test around the latched bomb position.
  function automatic logic inBlastBox(input logic [9:0] px, input logic [8:0] py,
                                      input logic [9:0] bx, input logic [8:0] by);
    return (32'(absDiffX(px, bx)) <= RADIUS) && (32'(absDiffY(py, by)) <= RADIUS);
  endfunction

  assign acceptNow = (state == IDLE) && bomb_request;
  assign redHit    = (state == BLAST) && inBlastBox(red_x, red_y, bombXReg, bombYReg);
  assign blueHit   = (state == BLAST) && inBlastBox(blue_x, blue_y, bombXReg, bombYReg);

  // Lifecycle FSM: accepts a request only in IDLE and times each phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      phaseCnt    <= '0;
      acceptedReg <= 1'b0;
      bombXReg    <= '0;
      bombYReg    <= '0;
    end else begin
      acceptedReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bomb_request) begin
            state       <= FUSE;
            phaseCnt    <= FUSE_LOAD;
            acceptedReg <= 1'b1;
            bombXReg    <= bomb_x_in;
            bombYReg    <= bomb_y_in;
          end
        end
        FUSE: begin
          if (phaseCnt == '0) begin
            state    <= BLAST;
            phaseCnt <= BLAST_LOAD;
          end else begin
            phaseCnt <= phaseCnt - 1'b1;
          end
        end
        BLAST: begin
          if (phaseCnt == '0) begin
            state    <= COOLDOWN;
            phaseCnt <= COOLDOWN_LOAD;
          end else begin
            phaseCnt <= phaseCnt - 1'b1;
          end
        end
        COOLDOWN: begin
          if (phaseCnt == '0) begin
            state    <= IDLE;
            phaseCnt <= '0;
          end else begin
            phaseCnt <= phaseCnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          phaseCnt <= '0;
        end
      endcase
    end
  end

  // Stun timers: run independently of the FSM; a hit loads a timer only when
  // that player is not already stunned and has not been hit by this bomb.
  always_ff @(posedge clk) begin
    if (reset) begin
      redCnt      <= '0;
      blueCnt     <= '0;
      redHitFlag  <= 1'b0;
      blueHitFlag <= 1'b0;
    end else begin
      if (redCnt != '0) redCnt <= redCnt - 1'b1;
      if (blueCnt != '0) blueCnt <= blueCnt - 1'b1;

      if (acceptNow) begin
        redHitFlag <= 1'b0;
      end else if (redHit && !redHitFlag && (redCnt == '0)) begin
        redCnt     <= STUN_LOAD;
        redHitFlag <= 1'b1;
      end

      if (acceptNow) begin
        blueHitFlag <= 1'b0;
      end else if (blueHit && !blueHitFlag && (blueCnt == '0)) begin
        blueCnt     <= STUN_LOAD;
        blueHitFlag <= 1'b1;
      end
    end
  end

  assign bomb_accepted  = acceptedReg;
  assign bomb_active    = (state == FUSE) || (state == BLAST);
  assign bomb_exploding = (state == BLAST);
  assign bomb_x         = bombXReg;
  assign bomb_y         = bombYReg;
  assign red_stun       = (redCnt != '0);
  assign blue_stun      = (blueCnt != '0);

endmodule

// File: doc/stun_controller.md
Name: stun_controller

Overview:
- Sequences the full bomb lifecycle: arm, fuse countdown, blast window, cooldown.
- During the blast window, checks both players (red, blue) against the blast box around the bomb.
- Owns per-player stun timers, so a stun ends after a fixed time instead of latching forever.
- Sits between player/bomb input logic and the movement and render blocks, which consume bomb_active, bomb_exploding and the two stun flags.

Parameters:
- FUSE_CYCLES, 100: cycles in FUSE state (must be >= 1).
- BLAST_CYCLES, 10: cycles in BLAST state (must be >= 1).
- STUN_CYCLES, 200: cycles a hit player stays stunned (must be >= 1).
- COOLDOWN_CYCLES, 50: cycles in COOLDOWN before a new bomb is accepted (must be >= 1).
- BLAST_RADIUS, 16: inclusive half-width of the square blast box, in pixels.
- CNT_W, 28: width of all internal counters; must hold the largest cycle parameter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- bomb_request  in  1  level request to drop a bomb at bomb_x_in/bomb_y_in.
- bomb_x_in  in  10  requested bomb X position.
- bomb_y_in  in  9  requested bomb Y position.
- red_x  in  10  red player X.
- red_y  in  9  red player Y.
- blue_x  in  10  blue player X.
- blue_y  in  9  blue player Y.
- bomb_accepted  out  1  one-cycle pulse when a request is taken.
- bomb_active  out  1  high in FUSE and BLAST.
- bomb_exploding  out  1  high in BLAST only.
- bomb_x  out  10  latched bomb X.
- bomb_y  out  9  latched bomb Y.
- red_stun  out  1  red player stunned.
- blue_stun  out  1  blue player stunned.

Behaviour:
- Reset (synchronous, active-high): takes effect on the next clk edge from any state.
  - state=IDLE; all counters and hit flags = 0.
  - All outputs = 0, including bomb_x/bomb_y and both stun flags.
  - Reset mid-stun or mid-fuse aborts immediately; no residual pulse.
- States and transitions:
  - IDLE: bomb_request sampled high at edge T -> state FUSE at T+1. At T+1: bomb_x/bomb_y latch the inputs, bomb_accepted=1 for exactly that cycle, and both per-bomb hit flags clear.
  - FUSE: lasts exactly FUSE_CYCLES cycles, then -> BLAST.
  - BLAST: lasts exactly BLAST_CYCLES cycles, then -> COOLDOWN.
  - COOLDOWN: lasts exactly COOLDOWN_CYCLES cycles, then -> IDLE.
- bomb_request is ignored (dropped, not queued) in any state other than IDLE.
  - A request held high through cooldown is accepted on the first IDLE cycle.
  - bomb_x/bomb_y are stable from acceptance until the next acceptance or reset.
- Hit test: evaluated every BLAST cycle against the current player positions.
  - Compute |px-bomb_x| and |py-bomb_y| as unsigned absolute differences at full input width, no wrap.
  - Hit when both differences are <= BLAST_RADIUS; a difference exactly equal to BLAST_RADIUS is a hit.
- Stun timers, one independent counter per player:
  - A hit in BLAST cycle k, with that player's hit flag clear and that player not currently stunned, loads STUN_CYCLES and sets the hit flag.
  - The stun flag goes high at k+1 and stays high for exactly STUN_CYCLES cycles.
  - Each player can be stunned at most once per bomb (hit flag).
  - A hit while the player is still stunned does not reload or extend the timer.
  - Red and blue hit in the same cycle are both stunned in parallel with identical timing.
- Stun timers keep running through COOLDOWN, IDLE and the next bomb's FUSE; state changes never clear them, only expiry or reset does.

Test Plan:
(All scenarios use FUSE=4, BLAST=2, STUN=5, COOLDOWN=3, R=16.)
- Basic lifecycle: reset, then request at (100,100) sampled at cycle 0.
  - bomb_accepted high at cycle 1 only.
  - bomb_active high cycles 1-6; bomb_exploding high cycles 5-6.
  - bomb_request high again at cycle 9 is not accepted; bomb_request high at cycle 10 is accepted, with bomb_accepted at 11.
- Radius boundary: bomb at (100,100), red at (116,84), blue at (117,100).
  - red_stun high cycles 6-10.
  - blue_stun stays 0.
- Simultaneous hits and single-hit rule: both players at (100,100) throughout BLAST.
  - red_stun and blue_stun both high cycles 6-10.
  - Neither is extended by the second BLAST cycle.
- Busy drop: bomb_request pulsed at cycle 3 during FUSE with position (300,200).
  - No bomb_accepted pulse.
  - bomb_x/bomb_y remain (100,100).
- Reset mid-operation: assert reset at cycle 7 while red_stun=1.
  - At cycle 8, every output = 0 and state = IDLE.
  - A request at cycle 8 yields bomb_accepted at 9.
